div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Sequential restoring divider; the inverse of the combinational `mul` block.
- Takes a 2N-bit dividend (the width of a `mul` product) and an N-bit divisor.
- Produces a 2N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Lives in ArithmeticOps next to `mul`; driven by the datapath through a start/done handshake.

Parameters:
- N, 4, divisor and remainder width. Dividend and quotient are 2N bits. Legal range is 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a division; sampled on a rising clk edge
- dividend  input  2N  numerator; captured when start is accepted
- divisor  input  N  denominator; captured when start is accepted
- quotient  output  2N  result; held stable from done until the next accepted start
- remainder  output  N  result; held with quotient
- busy  output  1  high while the division iterates
- done  output  1  one-cycle pulse when results become valid
- div_by_zero  output  1  set with done when divisor==0; held with the results

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - quotient, remainder, busy, done, div_by_zero and all internal registers are 0.
  - Reset asserted mid-operation aborts the division immediately. No done pulse is issued afterwards.
- States:
  - IDLE: waiting; busy=0, done=0.
  - RUN: iterating; busy=1.
  - DONE: results just written; done=1 for exactly this one cycle.
- Start acceptance:
  - start is accepted when state is IDLE or DONE (busy=0).
  - start while busy=1 is ignored. Operands are not recaptured and the result is unaffected.
  - On acceptance, dividend and divisor are latched internally. The inputs may change on the next cycle.
  - quotient, remainder and div_by_zero keep their old values until the new result is written.
- Divisor == 0:
  - On acceptance go directly to DONE at the next edge; no RUN cycles.
  - quotient = all ones (2^(2N)-1).
  - remainder = dividend[N-1:0].
  - div_by_zero = 1.
- Normal path:
  - On acceptance go to RUN; load partial remainder R = 0 (N+1 bits), Q = dividend, iteration counter = 0.
  - Each RUN cycle:
    - Shift {R,Q} left by 1.
    - Compute T = R - {1'b0,divisor}.
    - If T >= 0: R = T and Q[0] = 1; otherwise R is unchanged and Q[0] = 0.
  - After exactly 2N RUN cycles, go to DONE.
  - In DONE: quotient = Q, remainder = R[N-1:0], div_by_zero = 0.
- Latency (normal path):
  - start is sampled at edge k.
  - busy=1 after edges k+1 through k+2N.
  - done=1 and results are valid after edge k+2N+1.
  - Example, N=4: start at edge 0 → done visible after edge 9.
- Latency (divide by zero): done=1 after edge k+1.
- DONE exits:
  - To IDLE on the next edge if start=0.
  - To RUN, or back to DONE for divisor==0, if start=1. Back-to-back operations are allowed with no idle gap.
- Width and correctness rules:
  - Unsigned only.
  - Invariant: dividend == quotient*divisor + remainder, and remainder < divisor, for every divisor != 0.
  - quotient may need the full 2N bits (e.g. divisor=1).
- done is never asserted in IDLE or RUN. busy and done are never high together.

Test Plan:
- Reset, then start with dividend=15, divisor=5 (N=4) → busy high 8 cycles, then done pulse; quotient=3, remainder=0, div_by_zero=0.
- dividend=15, divisor=1, then dividend=200, divisor=7 issued back-to-back (start held high during the DONE cycle) → quotient=15, remainder=0; then quotient=28, remainder=4 done 9 cycles later. No IDLE cycle in between.
- dividend=255, divisor=0 → done one cycle after start; quotient=255, remainder=15, div_by_zero=1. A following 255/15 → quotient=17, remainder=0, div_by_zero=0.
- Start 100/3; pulse start with 9/9 on RUN cycle 3 → the second start is ignored; result is quotient=33, remainder=1; exactly one done pulse.
- Start 200/7, assert rst_n=0 on RUN cycle 4 → all outputs 0 immediately, no done pulse. After release, 45/6 → quotient=7, remainder=3.
- Random sweep of all 256×16 operand pairs with N=4 → the invariant holds and div_by_zero is exact for every pair; done appears exactly 9 cycles after start when divisor != 0.

Source files
------------

// File: rtl/div_seq.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per clock, with a start/done handshake. Companion of the mul block.
module div_seq #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    r_q, r_d;
  logic [2*N-1:0]  q_q, q_d;
  logic [N-1:0]    dvsr_q, dvsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  quot_q, quot_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // The stored remainder is always below the divisor, so it fits in N bits;
  // only the shifted value needs the extra top bit.
  logic [N:0]      r_sh_s;
  logic            ge_s;

  // Next-state, iteration datapath and result capture.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    r_sh_s  = {r_q, q_q[2*N-1]};
    ge_s    = (r_sh_s >= {1'b0, dvsr_q});

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvsr_d = divisor;
          if (divisor == {N{1'b0}}) begin
            state_d = DONE;
            quot_d  = {(2*N){1'b1}};
            rem_d   = dividend[N-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            r_d     = {N{1'b0}};
            q_d     = dividend;
            cnt_d   = {CW{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (ge_s) begin
          r_d = r_sh_s[N-1:0] - dvsr_q;
        end else begin
          r_d = r_sh_s[N-1:0];
        end
        q_d   = {q_q[2*N-2:0], ge_s};
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST) begin
          state_d = DONE;
          quot_d  = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= {N{1'b0}};
      q_q     <= {(2*N){1'b0}};
      dvsr_q  <= {N{1'b0}};
      cnt_q   <= {CW{1'b0}};
      quot_q  <= {(2*N){1'b0}};
      rem_q   <= {N{1'b0}};
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (N=4): handshake timing, divide by
// zero, ignored starts, reset abort and an exhaustive operand sweep.
module tb_div_seq;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int done_seen = 0;

  div_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy === 1'b1 && done === 1'b1) overlap++;
    if (done === 1'b1) done_seen++;
  end

  // Called at posedge+1. Returns edges until done (start edge counts as 1),
  // busy cycles seen, and {quotient,remainder,div_by_zero} one edge after start.
  task automatic issue(input logic [7:0] dvd, input logic [3:0] dvs,
                       output int lat, output int bcnt, output logic [12:0] snap);
    dividend = dvd; divisor = dvs; start = 1'b1;
    lat = 0; bcnt = 0; snap = 13'd0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (lat == 1) snap = {quotient, remainder, div_by_zero};
      if (busy === 1'b1) bcnt++;
    end while (done !== 1'b1 && lat < 40);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 15'd0) begin
      errors++;
      $display("FAIL reset_async: got %h, expected 0", {quotient, remainder, busy, done, div_by_zero});
    end
    dividend = 8'd15; divisor = 4'd5; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold: busy/done=%b, expected 00", {busy, done});
    end
    start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bc; logic [12:0] snap;
    issue(8'd15, 4'd5, lat, bc, snap);
    checks++;
    if (lat !== 9 || bc !== 8) begin
      errors++;
      $display("FAIL basic_timing: lat=%0d busy=%0d, expected lat=9 busy=8", lat, bc);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {8'd3, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b, expected q=3 r=0 dbz=0", quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL done_one_cycle: busy/done=%b, expected 00", {busy, done});
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [12:0] snap;
    issue(8'd15, 4'd1, lat, bc, snap);
    checks++;
    if ({quotient, remainder, div_by_zero} !== {8'd15, 4'd0, 1'b0} || lat !== 9) begin
      errors++;
      $display("FAIL b2b_first: q=%0d r=%0d dbz=%b lat=%0d, expected q=15 r=0 dbz=0 lat=9", quotient, remainder, div_by_zero, lat);
    end
    issue(8'd200, 4'd7, lat, bc, snap);
    checks++;
    if (lat !== 9 || bc !== 8) begin
      errors++;
      $display("FAIL b2b_timing: lat=%0d busy=%0d, expected lat=9 busy=8", lat, bc);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {8'd28, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second: q=%0d r=%0d dbz=%b, expected q=28 r=4 dbz=0", quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat, bc; logic [12:0] snap;
    issue(8'd255, 4'd0, lat, bc, snap);
    checks++;
    if (lat !== 1 || bc !== 0) begin
      errors++;
      $display("FAIL dz_timing: lat=%0d busy=%0d, expected lat=1 busy=0", lat, bc);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {8'd255, 4'd15, 1'b1}) begin
      errors++;
      $display("FAIL dz_result: q=%0d r=%0d dbz=%b, expected q=255 r=15 dbz=1", quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    issue(8'd255, 4'd15, lat, bc, snap);
    checks++;
    if (snap !== {8'd255, 4'd15, 1'b1}) begin
      errors++;
      $display("FAIL dz_held: got %h, expected %h", snap, {8'd255, 4'd15, 1'b1});
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {8'd17, 4'd0, 1'b0} || lat !== 9) begin
      errors++;
      $display("FAIL dz_followup: q=%0d r=%0d dbz=%b lat=%0d, expected q=17 r=0 dbz=0 lat=9", quotient, remainder, div_by_zero, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int lat, d0;
    d0 = done_seen;
    dividend = 8'd100; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 8'd0; divisor = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    dividend = 8'd9; divisor = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 4;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {8'd33, 4'd1, 1'b0} || lat !== 9) begin
      errors++;
      $display("FAIL ignore_result: q=%0d r=%0d dbz=%b lat=%0d, expected q=33 r=1 dbz=0 lat=9", quotient, remainder, div_by_zero, lat);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_seen - d0 !== 1) begin
      errors++;
      $display("FAIL ignore_pulses: done pulses=%0d, expected 1", done_seen - d0);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, d0; logic [12:0] snap;
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 15'd0) begin
      errors++;
      $display("FAIL abort_clear: got %h, expected 0", {quotient, remainder, busy, done, div_by_zero});
    end
    d0 = done_seen;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (done_seen !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: pulses=%0d busy=%b, expected 0 pulses busy=0", done_seen - d0, busy);
    end
    issue(8'd45, 4'd6, lat, bc, snap);
    checks++;
    if ({quotient, remainder, div_by_zero} !== {8'd7, 4'd3, 1'b0} || lat !== 9) begin
      errors++;
      $display("FAIL abort_recover: q=%0d r=%0d dbz=%b lat=%0d, expected q=7 r=3 dbz=0 lat=9", quotient, remainder, div_by_zero, lat);
    end
  endtask

  task automatic test_sweep();
    int lat, bc, qe, re, le; logic [12:0] snap; logic de;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(a[7:0], b[3:0], lat, bc, snap);
        if (b == 0) begin
          qe = 255; re = a % 16; de = 1'b1; le = 1;
        end else begin
          qe = a / b; re = a % b; de = 1'b0; le = 9;
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {qe[7:0], re[3:0], de} || lat !== le) begin
          errors++;
          $display("FAIL sweep %0d/%0d: q=%0d r=%0d dbz=%b lat=%0d, expected q=%0d r=%0d dbz=%b lat=%0d",
                   a, b, quotient, remainder, div_by_zero, lat, qe, re, de, le);
        end
      end
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL busy_done_overlap: cycles=%0d, expected 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
